// File: rtl/mem_map.sv
// mem_map: CPU data-port interconnect to NSLAVE memory-mapped slaves.
//   Decodes the CPU address against per-slave base/size regions. Slave loads
//   carry the offset relative to the start of the region. Read data comes back
//   LAT cycles after an accepted access. The CPU is stalled while the target
//   slave is busy, and an access that hits no region sets a sticky error flag.
// Optional feature: define MEM_MAP_WBUF_EN to add a one-entry posted-write
//   buffer. A CPU write to a busy slave can then retire without stalling.
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   load, address,   CPU write strobe, address and write data
//   in
//   busy             CPU must hold the access and retry (combinational)
//   out              read data, LAT cycles after an accepted access
//   err              sticky unmapped-access flag
//   s_load           one-hot slave write strobes (combinational)
//   s_address, s_in  region offset and write data, shared by all slaves
//   s_out, s_busy    packed slave read data and per-slave busy
module mem_map #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NSLAVE = 3,
    parameter logic [NSLAVE*ADDR_W-1:0] BASE = {16'h6000, 16'h4000, 16'h0000},
    parameter logic [NSLAVE*8-1:0] SIZE_LOG2 = {8'd0, 8'd13, 8'd14},
    parameter int unsigned LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [ADDR_W-1:0]        address,
    input  logic [DATA_W-1:0]        in,
    output logic                     busy,
    output logic [DATA_W-1:0]        out,
    output logic                     err,
    output logic [NSLAVE-1:0]        s_load,
    output logic [ADDR_W-1:0]        s_address,
    output logic [DATA_W-1:0]        s_in,
    input  logic [NSLAVE*DATA_W-1:0] s_out,
    input  logic [NSLAVE-1:0]        s_busy
);

    localparam int unsigned IDX_W = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

    // Offset mask of region i: the low SIZE_LOG2[i] address bits.
    function automatic logic [ADDR_W-1:0] region_mask(input int unsigned i);
        logic [ADDR_W-1:0] m;
        logic [7:0]        sz;
        sz = SIZE_LOG2[i*8 +: 8];
        for (int unsigned b = 0; b < ADDR_W; b++) begin
            m[b] = (b < 32'(sz));
        end
        return m;
    endfunction

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [ADDR_W-1:0] off;
    logic              push;

    logic [LAT-1:0]            tag_v;
    logic [LAT-1:0][IDX_W-1:0] tag_i;

`ifdef MEM_MAP_WBUF_EN
    logic              buf_full;
    logic [IDX_W-1:0]  buf_slave;
    logic [ADDR_W-1:0] buf_off;
    logic [DATA_W-1:0] buf_data;
    logic              drain;
    logic              capture;
`endif

    // Address decode; scanning downwards lets the lowest index win on overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        off     = '0;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            if ((address & ~region_mask(i)) == BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
                off     = address & region_mask(i);
            end
        end
    end

    // Stall, slave strobe and shared slave bus steering.
    always_comb begin
        busy      = 1'b0;
        s_load    = '0;
        s_address = off;
        s_in      = in;
`ifdef MEM_MAP_WBUF_EN
        drain   = buf_full && !s_busy[buf_slave];
        capture = 1'b0;
        if (drain) begin
            // A drain owns the slave bus for this cycle, so the CPU waits.
            busy              = 1'b1;
            s_load[buf_slave] = 1'b1;
            s_address         = buf_off;
            s_in              = buf_data;
        end else if (hit && !load && buf_full && (buf_slave == hit_idx)) begin
            // A read must not overtake a posted write to the same slave.
            busy = 1'b1;
        end else if (hit && s_busy[hit_idx]) begin
            if (load && !buf_full) begin
                capture = 1'b1;
            end else begin
                busy = 1'b1;
            end
        end else if (hit && load) begin
            s_load[hit_idx] = 1'b1;
        end
`else
        if (hit && s_busy[hit_idx]) begin
            busy = 1'b1;
        end else if (hit && load) begin
            s_load[hit_idx] = 1'b1;
        end
`endif
    end

    assign push = !busy && hit;

    // Read data: steer the slave named by the oldest tag stage.
    always_comb begin
        out = '0;
        if (tag_v[LAT-1]) begin
            out = s_out[32'(tag_i[LAT-1])*DATA_W +: DATA_W];
        end
    end

    // Tag pipeline, sticky error flag and posted-write buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v <= '0;
            tag_i <= '0;
            err   <= 1'b0;
`ifdef MEM_MAP_WBUF_EN
            buf_full  <= 1'b0;
            buf_slave <= '0;
            buf_off   <= '0;
            buf_data  <= '0;
`endif
        end else begin
            for (int k = LAT - 1; k >= 1; k--) begin
                tag_v[k] <= tag_v[k-1];
                tag_i[k] <= tag_i[k-1];
            end
            tag_v[0] <= push;
            tag_i[0] <= hit_idx;
            if (!busy && !hit) begin
                err <= 1'b1;
            end
`ifdef MEM_MAP_WBUF_EN
            if (drain) begin
                buf_full <= 1'b0;
            end else if (capture) begin
                buf_full  <= 1'b1;
                buf_slave <= hit_idx;
                buf_off   <= off;
                buf_data  <= in;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_map.sv
// tb_mem_map: directed bench for mem_map with LAT=1 (dut) and LAT=3 (dut3).
// The posted-write sequences follow MEM_MAP_WBUF_EN.
module tb_mem_map;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] address;
    logic [15:0] in;
    logic [47:0] s_out;
    logic [2:0]  s_busy;

    logic        busy, err, busy3, err3;
    logic [15:0] out, out3, s_address, s_address3, s_in, s_in3;
    logic [2:0]  s_load, s_load3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_map dut (
        .clk(clk), .reset(reset), .load(load), .address(address), .in(in),
        .busy(busy), .out(out), .err(err), .s_load(s_load),
        .s_address(s_address), .s_in(s_in), .s_out(s_out), .s_busy(s_busy)
    );

    mem_map #(.LAT(3)) dut3 (
        .clk(clk), .reset(reset), .load(load), .address(address), .in(in),
        .busy(busy3), .out(out3), .err(err3), .s_load(s_load3),
        .s_address(s_address3), .s_in(s_in3), .s_out(s_out), .s_busy(s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one cycle's CPU access at the falling edge, then let it settle.
    task automatic drive(input logic ld, input logic [15:0] a, input logic [15:0] d,
                         input logic [2:0] sb);
        @(negedge clk);
        load    = ld;
        address = a;
        in      = d;
        s_busy  = sb;
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        address = 16'h0000;
        in      = 16'h0000;
        s_busy  = 3'b000;
        s_out   = {16'h3333, 16'h2222, 16'h1111};
        repeat (2) @(negedge clk);

        // First cycle out of reset: read 0x0005 from slave 0.
        @(negedge clk);
        reset   = 1'b0;
        address = 16'h0005;
        s_out   = {16'h3333, 16'h2222, 16'h1234};
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_sload", 32'(s_load), 32'd0);
        chk("rd5_saddr", 32'(s_address), 32'h0005);

        drive(1'b0, 16'h0000, 16'h0000, 3'b000);
        chk("rd5_out", 32'(out), 32'h1234);
        chk("rd5_err", 32'(err), 32'd0);
        s_out = {16'h3333, 16'h2222, 16'h1111};

        // Direct write to slave 1.
        drive(1'b1, 16'h4010, 16'hBEEF, 3'b000);
        chk("wr_sload", 32'(s_load), 32'b010);
        chk("wr_saddr", 32'(s_address), 32'h0010);
        chk("wr_sin", 32'(s_in), 32'hBEEF);
        chk("wr_busy", 32'(busy), 32'd0);

        // Region boundaries.
        drive(1'b0, 16'h3FFF, 16'h0000, 3'b000);
        chk("top0_saddr", 32'(s_address), 32'h3FFF);
        chk("top0_sload", 32'(s_load), 32'd0);
        drive(1'b1, 16'h5FFF, 16'h0101, 3'b000);
        chk("top1_sload", 32'(s_load), 32'b010);
        chk("top1_saddr", 32'(s_address), 32'h1FFF);
        drive(1'b1, 16'h6000, 16'h0202, 3'b000);
        chk("kbd_sload", 32'(s_load), 32'b100);
        chk("kbd_saddr", 32'(s_address), 32'h0000);

`ifdef MEM_MAP_WBUF_EN
        // Posted write to busy slave 1, then a blocked second write and RAW read.
        drive(1'b1, 16'h4001, 16'hAAAA, 3'b010);
        chk("pw_busy", 32'(busy), 32'd0);
        chk("pw_sload0", 32'(s_load), 32'd0);
        drive(1'b1, 16'h4003, 16'h5555, 3'b010);
        chk("pw2_busy", 32'(busy), 32'd1);
        chk("pw_sload1", 32'(s_load), 32'd0);
        drive(1'b0, 16'h4002, 16'h0000, 3'b010);
        chk("raw_busy", 32'(busy), 32'd1);
        chk("pw_sload2", 32'(s_load), 32'd0);
        drive(1'b0, 16'h4002, 16'h0000, 3'b000);
        chk("drain_sload", 32'(s_load), 32'b010);
        chk("drain_saddr", 32'(s_address), 32'h0001);
        chk("drain_sin", 32'(s_in), 32'hAAAA);
        chk("drain_busy", 32'(busy), 32'd1);
        drive(1'b0, 16'h4002, 16'h0000, 3'b000);
        chk("raw_accept", 32'(busy), 32'd0);
        chk("raw_sload", 32'(s_load), 32'd0);
        chk("raw_saddr", 32'(s_address), 32'h0002);
        drive(1'b0, 16'h0000, 16'h0000, 3'b000);
        chk("raw_out", 32'(out), 32'h2222);

        // Reset while the buffer is full discards the posted write.
        drive(1'b1, 16'h4004, 16'h7777, 3'b010);
        chk("pw3_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        load  = 1'b0;
        address = 16'h0000;
        @(negedge clk);
        reset  = 1'b0;
        s_busy = 3'b000;
        #1;
        chk("rstbuf_sload", 32'(s_load), 32'd0);
        chk("rstbuf_busy", 32'(busy), 32'd0);
`else
        // Without a buffer every access to a busy slave stalls.
        drive(1'b1, 16'h4001, 16'hAAAA, 3'b010);
        chk("bw_busy", 32'(busy), 32'd1);
        chk("bw_sload", 32'(s_load), 32'd0);
        drive(1'b0, 16'h4002, 16'h0000, 3'b010);
        chk("br_busy", 32'(busy), 32'd1);
        drive(1'b0, 16'h0000, 16'h0000, 3'b010);
        chk("other_busy", 32'(busy), 32'd0);
        drive(1'b0, 16'h4002, 16'h0000, 3'b000);
        chk("br_accept", 32'(busy), 32'd0);
        chk("br_saddr", 32'(s_address), 32'h0002);
        drive(1'b0, 16'h0000, 16'h0000, 3'b000);
        chk("br_out", 32'(out), 32'h2222);
`endif

        // Unmapped read, then sticky err.
        drive(1'b0, 16'h7000, 16'h0000, 3'b000);
        chk("um_busy", 32'(busy), 32'd0);
        chk("um_err_pre", 32'(err), 32'd0);
        drive(1'b1, 16'h7000, 16'h9999, 3'b000);
        chk("um_out", 32'(out), 32'd0);
        chk("um_err", 32'(err), 32'd1);
        chk("umw_sload", 32'(s_load), 32'd0);
        drive(1'b0, 16'h0000, 16'h0000, 3'b000);
        drive(1'b0, 16'h0000, 16'h0000, 3'b000);
        chk("um_sticky", 32'(err), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("um_clear", 32'(err), 32'd0);

        // Back-to-back reads of all three slaves on both latencies.
        drive(1'b0, 16'h0000, 16'h0000, 3'b000);
        drive(1'b0, 16'h4000, 16'h0000, 3'b000);
        chk("l1_out0", 32'(out), 32'h1111);
        drive(1'b0, 16'h6000, 16'h0000, 3'b000);
        chk("l1_out1", 32'(out), 32'h2222);
        drive(1'b0, 16'h0000, 16'h0000, 3'b000);
        chk("l1_out2", 32'(out), 32'h3333);
        chk("l3_out0", 32'(out3), 32'h1111);
        drive(1'b0, 16'h0000, 16'h0000, 3'b000);
        chk("l3_out1", 32'(out3), 32'h2222);
        drive(1'b0, 16'h0000, 16'h0000, 3'b000);
        chk("l3_out2", 32'(out3), 32'h3333);
        chk("l3_err", 32'(err3), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_map.md
# mem_map

Parametrised memory-map interconnect between the CPU data port and N memory-mapped slaves (RAM, screen VRAM, keyboard, later peripherals). It decodes CPU addresses against per-slave base/size regions and issues slave loads with region-relative offsets. It returns read data aligned to a fixed read latency, stalls the CPU on busy slaves, and flags unmapped accesses. An optional one-entry posted-write buffer lets CPU writes to a busy slave (e.g. VRAM during scan-out) retire without stalling.

## Interface
- ADDR_W, 16, CPU/slave address width
- DATA_W, 16, data width
- NSLAVE, 3, number of slaves (1..8)
- BASE, {16'h6000,16'h4000,16'h0000}, packed NSLAVE×ADDR_W base addresses, slave 0 in LSBs
- SIZE_LOG2, {8'd0,8'd13,8'd14}, packed NSLAVE×8 region sizes as log2 words
- LAT, 1, slave read latency in cycles (1..4), identical for all slaves

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- load  in  1  CPU write strobe
- address  in  ADDR_W  CPU address
- in  in  DATA_W  CPU write data
- busy  out  1  CPU must hold load/address/in and retry next cycle
- out  out  DATA_W  read data, LAT cycles after an accepted access
- err  out  1  sticky unmapped-access flag
- s_load  out  NSLAVE  one-hot slave write strobes
- s_address  out  ADDR_W  region offset, shared by all slaves
- s_in  out  DATA_W  write data, shared by all slaves
- s_out  in  NSLAVE×DATA_W  slave read data, packed
- s_busy  in  NSLAVE  slave cannot accept an access this cycle

## Operation
- Decode: slave i hits when (address & ~((1<<SIZE_LOG2[i])-1)) == BASE[i]; lowest index wins on overlap; no hit = unmapped.
- Offset: s_address = address & ((1<<SIZE_LOG2)-1) of the hit slave. Drain cycles use the buffered offset instead.
- Accepted access: busy=0 in that cycle. A write pulses s_load[hit] for that cycle only.
- Tag pipeline: LAT stages of {valid, slave index}, shifted every cycle. An accepted mapped access pushes valid+index; stall or unmapped pushes invalid.
- out = s_out[tag] when the stage-LAT tag is valid, else 0.
- Unmapped: write dropped; read returns 0 after LAT. err set, cleared only by reset.
- Write buffer (macro on): one entry {slave, offset, data, full}.
  - Write to a slave with s_busy=1 and buffer empty: captured, accepted, busy=0, no s_load.
  - Drain: buffer full and s_busy[buf_slave]=0 → s_load[buf_slave]=1 with buffered offset and data; buffer empty next cycle. Drain has priority: busy=1 to the CPU in a drain cycle.
- Stall (busy=1) when any of the following holds:
  - the hit slave has s_busy=1 and the access cannot be buffered (a read, or buffer full);
  - a read hits the slave targeted by a full buffer (read-after-write ordering);
  - a drain occurs in that cycle.

## Timing
- Reset values: busy=0, out=0, err=0, s_load=0, buffer empty, all tags invalid.
- Write: s_load is combinational in the cycle the write is accepted. Posted write reaches the slave at the first cycle with s_busy low, no earlier than the cycle after capture.
- Read accepted at cycle T → out valid during cycle T+LAT only.
- Back-to-back accepted reads give one result per cycle.
- Reset mid-drain or with the buffer full discards the buffered write; in-flight tags are cleared.
- busy depends combinationally on address, load, s_busy and buffer state; no registered-busy bubble.

## Configuration
- MEM_MAP_WBUF_EN defined: posted-write buffer as above.
- MEM_MAP_WBUF_EN undefined: no buffer. Any access to a slave with s_busy=1 stalls, and no drain cycles exist.

## Test plan
- Reset, then read 0x0005 with slave0 s_out=16'h1234, LAT=1 → busy=0; out=16'h1234 in the next cycle; err=0.
- Write 16'hBEEF to 0x4010 with s_busy[1]=0 → s_load=3'b010 and s_address=0x0010 in the same cycle.
- Macro on: write 16'hAAAA to 0x4001 with s_busy[1]=1 for 3 cycles → busy=0 on the write; s_load=0 for 3 cycles; then one s_load[1] pulse with s_address=1 and s_in=16'hAAAA. Second busy-slave write while the buffer is full → busy=1.
- Macro on: read 0x4002 while the buffer holds a slave-1 write → busy=1 until the drain completes, then the read is accepted.
- Read 0x7000 (unmapped) → out=0 after LAT; err=1 and stays 1 until reset.
- LAT=3: reads of 0x0000, 0x4000, 0x6000 on consecutive cycles → out sequence slave0, slave1, slave2 data on cycles T+3, T+4, T+5.
